// File: rtl/irq_shim_pkg.sv
// Shared types and helpers for the MSI-X interrupt coalescing shim.
package irq_shim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } chan_state_e;

  // Width of the holdoff down-counter; it is loaded with HOLDOFF_CYCLES-1.
  function automatic int hold_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_shim_chan.sv
// One interrupt channel: request/ack handshake FSM, edge backlog counter,
// re-issue holdoff and sticky overflow flag.
module irq_shim_chan
  import irq_shim_pkg::*;
#(
  parameter bit LEVEL          = 1'b0,
  parameter int CNT_W          = 4,
  parameter int HOLDOFF_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic s_req_i,
  input  logic decouple_i,
  input  logic m_ack_i,
  input  logic ovf_clr_i,
  output logic m_req_o,
  output logic s_ack_o,
  output logic ovf_o
);

  localparam int HW = hold_w(HOLDOFF_CYCLES);
  localparam int HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] BL_MAX = '1;

  chan_state_e      state_q;
  logic [CNT_W-1:0] backlog_q;
  logic [HW-1:0]    hold_q;
  logic             prev_q;
  logic             stale_q;
  logic             m_req_q;
  logic             s_ack_q;
  logic             ovf_q;

  logic edge_ev, can_issue, trigger, issue, consume, overflow;

  assign edge_ev   = !LEVEL && !decouple_i && s_req_i && !prev_q;
  // The last holdoff cycle doubles as IDLE so the gap is exactly HOLDOFF_CYCLES.
  assign can_issue = !decouple_i &&
                     (state_q == ST_IDLE || (state_q == ST_HOLD && hold_q == '0));
  assign trigger   = LEVEL ? s_req_i : (edge_ev || backlog_q != '0);
  assign issue     = can_issue && trigger;
  assign consume   = issue && !LEVEL;
  assign overflow  = edge_ev && !consume && backlog_q == BL_MAX;

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the backlog counter, is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      backlog_q <= '0;
      hold_q    <= '0;
      prev_q    <= 1'b0;
      stale_q   <= 1'b0;
      m_req_q   <= 1'b0;
      s_ack_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      s_ack_q <= 1'b0;
      prev_q  <= s_req_i && !decouple_i;

      if (decouple_i)
        backlog_q <= '0;
      else if (edge_ev && !consume && backlog_q != BL_MAX)
        backlog_q <= backlog_q + 1'b1;
      else if (!edge_ev && consume)
        backlog_q <= backlog_q - 1'b1;

      if (overflow)
        ovf_q <= 1'b1;
      else if (ovf_clr_i)
        ovf_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q <= ST_REQ;
            m_req_q <= 1'b1;
            stale_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (decouple_i)
            stale_q <= 1'b1;
          if (m_ack_i) begin
            m_req_q <= 1'b0;
            s_ack_q <= !stale_q && !decouple_i;
            hold_q  <= HW'(HOLD_LOAD);
            state_q <= (HOLDOFF_CYCLES > 0) ? ST_HOLD : ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (issue) begin
            state_q <= ST_REQ;
            m_req_q <= 1'b1;
            stale_q <= 1'b0;
          end else if (hold_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_req_o = m_req_q;
  assign s_ack_o = s_ack_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/irq_coalesce_shim.sv
// MSI-X interrupt shim between a reconfigurable partition and the XDMA user
// IRQ port: one irq_shim_chan per channel plus the decouple status register.
module irq_coalesce_shim
  import irq_shim_pkg::*;
#(
  parameter int                 IRQ_NUM        = 16,
  parameter logic [IRQ_NUM-1:0] LEVEL_MASK     = '0,
  parameter int                 CNT_W          = 4,
  parameter int                 HOLDOFF_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IRQ_NUM-1:0] s_irq_req,
  output logic [IRQ_NUM-1:0] s_irq_ack,
  output logic [IRQ_NUM-1:0] m_irq_req,
  input  logic [IRQ_NUM-1:0] m_irq_ack,
  output logic [IRQ_NUM-1:0] irq_ovf,
  input  logic [IRQ_NUM-1:0] irq_ovf_clr,
  input  logic               decouple_control,
  output logic               decouple_status
);

  logic decouple_status_q;

  for (genvar i = 0; i < IRQ_NUM; i++) begin : g_chan
    irq_shim_chan #(
      .LEVEL          (LEVEL_MASK[i]),
      .CNT_W          (CNT_W),
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .s_req_i    (s_irq_req[i]),
      .decouple_i (decouple_control),
      .m_ack_i    (m_irq_ack[i]),
      .ovf_clr_i  (irq_ovf_clr[i]),
      .m_req_o    (m_irq_req[i]),
      .s_ack_o    (s_irq_ack[i]),
      .ovf_o      (irq_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) decouple_status_q <= 1'b0;
    else       decouple_status_q <= decouple_control;
  end

  assign decouple_status = decouple_status_q;

endmodule

// File: tb/tb_irq_coalesce_shim.sv
// Directed bench: instance a (no holdoff, CNT_W=2, ch2 level) and instance h (holdoff 4).
module tb_irq_coalesce_shim;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s_req, s_ack, m_req, m_ack, ovf, ovf_clr;
  logic       dc, dcs;
  logic [3:0] hs_req, hs_ack, hm_req, hm_ack, hovf, hovf_clr;
  logic       hdc, hdcs;

  int total = 0;
  int bad   = 0;
  int ack_cnt;

  always #5 clk = ~clk;

  irq_coalesce_shim #(
    .IRQ_NUM(4), .LEVEL_MASK(4'b0100), .CNT_W(2), .HOLDOFF_CYCLES(0)
  ) dut (
    .clk(clk), .reset(reset), .s_irq_req(s_req), .s_irq_ack(s_ack),
    .m_irq_req(m_req), .m_irq_ack(m_ack), .irq_ovf(ovf), .irq_ovf_clr(ovf_clr),
    .decouple_control(dc), .decouple_status(dcs)
  );

  irq_coalesce_shim #(
    .IRQ_NUM(4), .LEVEL_MASK(4'b0000), .CNT_W(4), .HOLDOFF_CYCLES(4)
  ) dut_h (
    .clk(clk), .reset(reset), .s_irq_req(hs_req), .s_irq_ack(hs_ack),
    .m_irq_req(hm_req), .m_irq_ack(hm_ack), .irq_ovf(hovf), .irq_ovf_clr(hovf_clr),
    .decouple_control(hdc), .decouple_status(hdcs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input int ch);
    s_req[ch] = 1'b1; tick();
    s_req[ch] = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b1; s_req = '0; m_ack = '0; ovf_clr = '0; dc = 1'b0;
    hs_req = '0; hm_ack = '0; hovf_clr = '0; hdc = 1'b0;
    tick(); tick();
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_s_ack", 32'(s_ack), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_dcs", 32'(dcs), 0);
    chk("rst_h_m_req", 32'(hm_req), 0);
    reset = 1'b0;
    tick();

    // Edge ch0: request the cycle after the edge, ack pulse only once.
    s_req[0] = 1'b1; tick();
    chk("e0_req_up", 32'(m_req[0]), 1);
    s_req[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("e0_req_hold", 32'(m_req[0]), 1);
      chk("e0_no_ack", 32'(s_ack[0]), 0);
    end
    m_ack[0] = 1'b1; tick();
    chk("e0_req_drop", 32'(m_req[0]), 0);
    chk("e0_ack_pulse", 32'(s_ack[0]), 1);
    m_ack[0] = 1'b0; tick();
    chk("e0_ack_end", 32'(s_ack[0]), 0);
    chk("e0_no_reissue", 32'(m_req[0]), 0);

    // Ch1: three extra edges while in REQ are all re-issued.
    pulse_a(1);
    chk("bl_first", 32'(m_req[1]), 1);
    for (int i = 0; i < 3; i++) pulse_a(1);
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_ack[1] = 1'b1; tick();
      chk("bl_drop", 32'(m_req[1]), 0);
      if (s_ack[1]) ack_cnt++;
      m_ack[1] = 1'b0; tick();
      chk("bl_reissue", 32'(m_req[1]), (i < 3) ? 1 : 0);
    end
    chk("bl_ack_count", ack_cnt, 4);
    chk("bl_no_ovf", 32'(ovf[1]), 0);

    // Ch1 overflow with CNT_W=2: backlog saturates at 3.
    pulse_a(1);
    for (int i = 0; i < 5; i++) begin
      s_req[1] = 1'b1; tick();
      if (i == 2) chk("ovf_at_sat_clear", 32'(ovf[1]), 0);
      s_req[1] = 1'b0; tick();
    end
    chk("ovf_set", 32'(ovf[1]), 1);
    ovf_clr[1] = 1'b1; tick();
    chk("ovf_clr", 32'(ovf[1]), 0);
    ovf_clr[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_ack[1] = 1'b1; tick();
      m_ack[1] = 1'b0; tick();
      chk("ovf_drain", 32'(m_req[1]), (i < 3) ? 1 : 0);
    end

    // Holdoff 4 with backlog 1: low for exactly four cycles after the ack.
    hs_req[0] = 1'b1; tick(); hs_req[0] = 1'b0; tick();
    hs_req[0] = 1'b1; tick(); hs_req[0] = 1'b0; tick();
    chk("ho_req", 32'(hm_req[0]), 1);
    hm_ack[0] = 1'b1; tick();
    chk("ho_drop", 32'(hm_req[0]), 0);
    chk("ho_ack", 32'(hs_ack[0]), 1);
    hm_ack[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ho_gap", 32'(hm_req[0]), 0);
    end
    tick();
    chk("ho_reissue", 32'(hm_req[0]), 1);
    hm_ack[0] = 1'b1; tick(); hm_ack[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("ho_idle", 32'(hm_req[0]), 0);

    // Decouple during REQ on ch3; source high at recouple is a new edge.
    pulse_a(3);
    chk("dc_req", 32'(m_req[3]), 1);
    dc = 1'b1; s_req[3] = 1'b1; tick();
    chk("dc_status_up", 32'(dcs), 1);
    chk("dc_req_kept", 32'(m_req[3]), 1);
    tick();
    dc = 1'b0; tick();
    chk("dc_status_down", 32'(dcs), 0);
    s_req[3] = 1'b0; tick();
    m_ack[3] = 1'b1; tick();
    chk("dc_stale_drop", 32'(m_req[3]), 0);
    chk("dc_stale_swallow", 32'(s_ack[3]), 0);
    m_ack[3] = 1'b0; tick();
    chk("dc_reassert", 32'(m_req[3]), 1);
    m_ack[3] = 1'b1; tick();
    chk("dc_new_ack", 32'(s_ack[3]), 1);
    m_ack[3] = 1'b0; tick();
    chk("dc_done", 32'(m_req[3]), 0);

    // Level ch2: held high for three acks, then dropped.
    s_req[2] = 1'b1; tick();
    chk("lv_req", 32'(m_req[2]), 1);
    ack_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      m_ack[2] = 1'b1; tick();
      chk("lv_drop", 32'(m_req[2]), 0);
      if (s_ack[2]) ack_cnt++;
      m_ack[2] = 1'b0;
      if (i == 2) s_req[2] = 1'b0;
      tick();
      chk("lv_reissue", 32'(m_req[2]), (i < 2) ? 1 : 0);
    end
    chk("lv_ack_count", ack_cnt, 3);
    tick(); tick();
    chk("lv_quiet", 32'(m_req[2]), 0);
    chk("lv_no_ovf", 32'(ovf[2]), 0);

    // Reset mid-request drops the request; a late ack is ignored.
    pulse_a(0);
    chk("mr_req", 32'(m_req[0]), 1);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("mr_drop", 32'(m_req[0]), 0);
    m_ack[0] = 1'b1; tick();
    m_ack[0] = 1'b0;
    chk("mr_late_ack", 32'(s_ack[0]), 0);
    chk("mr_still_idle", 32'(m_req[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
